// File: rtl/dispatch_issue_unit.sv
// Dispatch/issue unit: in-order dispatch queue feeding a set of execution
// units over valid/ready, plus a round-robin arbiter that funnels unit
// results onto a single registered common data bus.

// Per-unit decode: issue strobe for this unit and its result grant.
module diu_lane #(
  parameter int EXEC_WIDTH = 4,
  parameter int GW         = 2,
  parameter int IDX        = 0
) (
  input  logic                  head_ok,
  input  logic [EXEC_WIDTH-1:0] head_id,
  input  logic                  found,
  input  logic [GW-1:0]         gnt,
  output logic                  issue_vld,
  output logic                  ack
);
  assign issue_vld = head_ok && (head_id == EXEC_WIDTH'(IDX));
  assign ack       = found && (gnt == GW'(IDX));
endmodule

module dispatch_issue_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int TAG_WIDTH  = 7,
  parameter int EXEC_WIDTH = 4,
  parameter int NUM_EU     = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           dispatch,
  input  logic [DATA_WIDTH-1:0]          op1,
  input  logic [DATA_WIDTH-1:0]          op2,
  input  logic [EXEC_WIDTH-1:0]          executionID_DU,
  input  logic [TAG_WIDTH-1:0]           executionTag,
  output logic                           dq_full,
  output logic [NUM_EU-1:0]              eu_valid,
  input  logic [NUM_EU-1:0]              eu_ready,
  output logic [DATA_WIDTH-1:0]          eu_op1,
  output logic [DATA_WIDTH-1:0]          eu_op2,
  output logic [TAG_WIDTH-1:0]           eu_tag,
  input  logic [NUM_EU-1:0]              res_valid,
  input  logic [NUM_EU*TAG_WIDTH-1:0]    res_tag,
  input  logic [NUM_EU*DATA_WIDTH-1:0]   res_data,
  output logic [NUM_EU-1:0]              res_ack,
  output logic                           cdb_valid,
  output logic [TAG_WIDTH-1:0]           cdb_tag,
  output logic [DATA_WIDTH-1:0]          cdb_data,
  output logic                           err_bad_id
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int GW = (NUM_EU > 1) ? $clog2(NUM_EU) : 1;
  localparam logic [EXEC_WIDTH:0] NUM_EU_X = (EXEC_WIDTH + 1)'(NUM_EU);
  localparam logic [CW-1:0]       DEPTH_C  = CW'(FIFO_DEPTH);
  localparam logic [GW-1:0]       LAST_EU  = GW'(NUM_EU - 1);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] op_a;
    logic [DATA_WIDTH-1:0] op_b;
    logic [EXEC_WIDTH-1:0] id;
    logic [TAG_WIDTH-1:0]  tag;
  } dq_entry_t;

  dq_entry_t       mem [FIFO_DEPTH];
  dq_entry_t       head, in_pkt;
  logic [PW-1:0]   rd_ptr, wr_ptr;
  logic [CW-1:0]   count;
  logic            head_ok, head_bad, push, pop;

  logic [NUM_EU-1:0][TAG_WIDTH-1:0]  res_tag_a;
  logic [NUM_EU-1:0][DATA_WIDTH-1:0] res_data_a;
  logic [GW-1:0]   rr_ptr, gnt;
  logic            found;

  assign res_tag_a  = res_tag;
  assign res_data_a = res_data;

  assign in_pkt   = '{op_a: op1, op_b: op2, id: executionID_DU, tag: executionTag};
  assign head     = mem[rd_ptr];
  assign dq_full  = (count == DEPTH_C);
  assign head_ok  = (count != '0) && ({1'b0, head.id} < NUM_EU_X);
  // An out-of-range ID at the head is discarded so it cannot wedge the queue.
  assign head_bad = (count != '0) && !head_ok;
  assign push     = dispatch & ~dq_full;
  assign pop      = head_bad | (|(eu_valid & eu_ready));

  assign eu_op1 = head.op_a;
  assign eu_op2 = head.op_b;
  assign eu_tag = head.tag;

  for (genvar i = 0; i < NUM_EU; i++) begin : g_lane
    diu_lane #(.EXEC_WIDTH(EXEC_WIDTH), .GW(GW), .IDX(i)) u_lane (
      .head_ok   (head_ok),
      .head_id   (head.id),
      .found     (found),
      .gnt       (gnt),
      .issue_vld (eu_valid[i]),
      .ack       (res_ack[i])
    );
  end

  // Round-robin search: first requesting unit at or after rr_ptr, wrapping.
  always_comb begin
    int idx;
    found = 1'b0;
    gnt   = rr_ptr;
    idx   = 0;
    for (int k = 0; k < NUM_EU; k++) begin
      idx = (int'(rr_ptr) + k) % NUM_EU;
      if (!found && res_valid[GW'(idx)]) begin
        found = 1'b1;
        gnt   = GW'(idx);
      end
    end
  end

  // Queue storage, pointers, occupancy and the sticky bad-ID flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      err_bad_id <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= in_pkt;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
      if (head_bad) err_bad_id <= 1'b1;
    end
  end

  // CDB register: broadcast the granted result one cycle after its ack.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cdb_valid <= 1'b0;
      cdb_tag   <= '0;
      cdb_data  <= '0;
      rr_ptr    <= '0;
    end else if (found) begin
      cdb_valid <= 1'b1;
      cdb_tag   <= res_tag_a[gnt];
      cdb_data  <= res_data_a[gnt];
      rr_ptr    <= (gnt == LAST_EU) ? '0 : gnt + 1'b1;
    end else begin
      cdb_valid <= 1'b0;
    end
  end
endmodule
